muldiv_seq: RTL and testbench

Iterative multiply/divide engine for the multicycle ARM core. It executes MUL, UMULL, SMULL and UDIV over WIDTH cycles using a single shared adder/subtractor. The main controller sequences it through a Start/Busy/Done handshake and waits in an execute state until Done. ResultLo and ResultHi feed the two result writes, RegWrite and RegWrite2.

---
 rtl/muldiv_pkg.sv | 16 +
 rtl/muldiv_seq.sv | 153 +++++++++++++++
 tb/tb_muldiv_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide engine and its controller.
// Op encodings are also used by the controller decode.
package muldiv_pkg;

   localparam logic [1:0] OP_MUL   = 2'b00;
   localparam logic [1:0] OP_UMULL = 2'b01;
   localparam logic [1:0] OP_SMULL = 2'b10;
   localparam logic [1:0] OP_UDIV  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIN  = 2'b10
   } state_t;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative MUL/UMULL/SMULL/UDIV engine: one bit per cycle through a single
// WIDTH+1 bit adder/subtractor, Start/Busy/Done handshake.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] ResultLo,
   output logic [WIDTH-1:0] ResultHi,
   output logic             DivByZero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state_reg;
   logic [CW-1:0]    count_reg;
   logic [1:0]       op_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH:0]   hi_reg;
   logic [WIDTH-1:0] lo_reg;
   logic             neg_reg;
   logic             busy_reg;
   logic             done_reg;
   logic             dbz_reg;
   logic [WIDTH-1:0] res_lo_reg;
   logic [WIDTH-1:0] res_hi_reg;

   logic             is_div;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   alu_x;
   logic [WIDTH:0]   alu_y;
   logic [WIDTH:0]   alu_out;
   logic [WIDTH:0]   hi_next;
   logic [WIDTH-1:0] lo_next;
   logic [2*WIDTH-1:0] product;
   logic [2*WIDTH-1:0] product_fix;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             smull_start;

   assign smull_start = (Op == OP_SMULL);
   assign a_mag = (smull_start && SrcA[WIDTH-1]) ? -SrcA : SrcA;
   assign b_mag = (smull_start && SrcB[WIDTH-1]) ? -SrcB : SrcB;

   // One shared adder: multiply adds the multiplicand into Hi, divide subtracts
   // the divisor from the remainder shifted left by one dividend bit.
   assign is_div    = (op_reg == OP_UDIV);
   assign div_shift = {hi_reg[WIDTH-1:0], lo_reg[WIDTH-1]};
   assign alu_x     = is_div ? div_shift : hi_reg;
   assign alu_y     = is_div ? {1'b0, b_reg} : (lo_reg[0] ? {1'b0, a_reg} : '0);
   assign alu_out   = is_div ? (alu_x - alu_y) : (alu_x + alu_y);

   always_comb begin
      hi_next = '0;
      lo_next = '0;
      if (is_div) begin
         if (alu_out[WIDTH]) begin
            hi_next = div_shift;
            lo_next = {lo_reg[WIDTH-2:0], 1'b0};
         end else begin
            hi_next = alu_out;
            lo_next = {lo_reg[WIDTH-2:0], 1'b1};
         end
      end else begin
         hi_next = {1'b0, alu_out[WIDTH:1]};
         lo_next = {alu_out[0], lo_reg[WIDTH-1:1]};
      end
   end

   assign product     = {hi_next[WIDTH-1:0], lo_next};
   assign product_fix = neg_reg ? -product : product;

   // Results of the final iteration are registered on the edge that enters FIN,
   // so Done is visible while in FIN and the next Start is taken one cycle later.
   // The divide-by-zero path enters FIN with Done low and raises it there.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         count_reg  <= '0;
         op_reg     <= OP_MUL;
         a_reg      <= '0;
         b_reg      <= '0;
         hi_reg     <= '0;
         lo_reg     <= '0;
         neg_reg    <= 1'b0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         dbz_reg    <= 1'b0;
         res_lo_reg <= '0;
         res_hi_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (Start) begin
                  op_reg    <= Op;
                  a_reg     <= a_mag;
                  b_reg     <= b_mag;
                  hi_reg    <= '0;
                  lo_reg    <= (Op == OP_UDIV) ? SrcA : b_mag;
                  neg_reg   <= smull_start && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                  count_reg <= CW'(WIDTH - 1);
                  dbz_reg   <= 1'b0;
                  busy_reg  <= 1'b1;
                  state_reg <= ((Op == OP_UDIV) && (SrcB == '0)) ? FIN : RUN;
               end
            end
            RUN: begin
               hi_reg <= hi_next;
               lo_reg <= lo_next;
               if (count_reg == '0) begin
                  res_lo_reg <= is_div ? lo_next : product_fix[WIDTH-1:0];
                  res_hi_reg <= is_div ? hi_next[WIDTH-1:0] : product_fix[2*WIDTH-1:WIDTH];
                  done_reg   <= 1'b1;
                  busy_reg   <= 1'b0;
                  state_reg  <= FIN;
               end else begin
                  count_reg <= count_reg - CW'(1);
               end
            end
            FIN: begin
               if (done_reg) begin
                  done_reg  <= 1'b0;
                  state_reg <= IDLE;
               end else begin
                  res_lo_reg <= '1;
                  res_hi_reg <= lo_reg;
                  dbz_reg    <= 1'b1;
                  done_reg   <= 1'b1;
                  busy_reg   <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign Busy      = busy_reg;
   assign Done      = done_reg;
   assign ResultLo  = res_lo_reg;
   assign ResultHi  = res_hi_reg;
   assign DivByZero = dbz_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases, handshake corner cases
// and randomized operations against a plain-arithmetic reference model.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        Start;
   logic [1:0]  Op;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        Busy;
   logic        Done;
   logic [31:0] ResultLo;
   logic [31:0] ResultHi;
   logic        DivByZero;

   int tests_run = 0;
   int tests_failed = 0;

   muldiv_seq #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
      .Busy(Busy), .Done(Done), .ResultLo(ResultLo), .ResultHi(ResultHi),
      .DivByZero(DivByZero)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: full-width arithmetic on the operation's definition.
   function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] lo, output logic [31:0] hi,
                                 output logic dbz, output int lat);
      logic [63:0] p;
      dbz = 1'b0;
      lat = 33;
      case (op)
         2'b00, 2'b01: p = {32'b0, a} * {32'b0, b};
         2'b10:        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
         default: begin
            if (b == 32'd0) begin
               p   = {a, 32'hFFFF_FFFF};
               dbz = 1'b1;
               lat = 2;
            end else begin
               p = {a % b, a / b};
            end
         end
      endcase
      lo = p[31:0];
      hi = p[63:32];
   endfunction

   // Issues one op; Start is raised in the current cycle. Returns in the Done cycle.
   // A nonzero inject raises a stray Start in that cycle of the operation.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inject, input string name);
      logic [31:0] elo, ehi;
      logic        edbz;
      int          elat;
      int          k;
      bit          hs_ok;
      model(op, a, b, elo, ehi, edbz, elat);
      Op = op; SrcA = a; SrcB = b; Start = 1'b1;
      step();
      Start = 1'b0;
      Op = 2'($urandom); SrcA = $urandom; SrcB = $urandom;
      k = 1;
      hs_ok = 1'b1;
      while (Done !== 1'b1 && k < 60) begin
         if (Busy !== 1'b1) hs_ok = 1'b0;
         if (k == 1 && DivByZero !== 1'b0) hs_ok = 1'b0;
         Start = (k == inject);
         step();
         k++;
      end
      Start = 1'b0;
      tests_run++;
      if (k >= 60) begin
         tests_failed++;
         $display("[TB] FAIL %s timeout: no Done within %0d cycles", name, k);
         return;
      end
      $display("[TB] %s op=%0d a=%h b=%h -> lo=%h hi=%h dbz=%0b lat=%0d", name, op, a, b,
               ResultLo, ResultHi, DivByZero, k);
      if (k != elat) begin
         tests_failed++;
         $display("[TB] FAIL %s latency: got %0d expected %0d", name, k, elat);
      end
      tests_run++;
      if (!hs_ok || Busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL %s handshake: busy/dbz-clear wrong (Busy at Done=%b)", name, Busy);
      end
      tests_run++;
      if (ResultLo !== elo || ResultHi !== ehi || DivByZero !== edbz) begin
         tests_failed++;
         $display("[TB] FAIL %s result: got lo=%h hi=%h dbz=%b expected lo=%h hi=%h dbz=%b",
                  name, ResultLo, ResultHi, DivByZero, elo, ehi, edbz);
      end
   endtask

   task automatic check_idle_zero(input string name);
      tests_run++;
      if (Busy !== 1'b0 || Done !== 1'b0 || ResultLo !== 32'd0 || ResultHi !== 32'd0 ||
          DivByZero !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL %s: got busy=%b done=%b lo=%h hi=%h dbz=%b expected all zero",
                  name, Busy, Done, ResultLo, ResultHi, DivByZero);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; Start = 1'b0; Op = 2'b00; SrcA = '0; SrcB = '0;
      repeat (3) step();
      reset = 1'b0;
      check_idle_zero("reset_state");
      step();
      check_idle_zero("idle_after_reset");
   endtask

   task automatic test_directed();
      do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "umull_max"); step();
      do_op(2'b00, 32'd12345, 32'd6789, 0, "mul_small"); step();
      do_op(2'b10, 32'hFFFF_FFFE, 32'd3, 0, "smull_neg"); step();
      do_op(2'b10, 32'h8000_0000, 32'h8000_0000, 0, "smull_min"); step();
      do_op(2'b11, 32'd100, 32'd7, 0, "udiv_100_7"); step();
      do_op(2'b11, 32'hFFFF_FFFF, 32'd1, 0, "udiv_by_1"); step();
   endtask

   task automatic test_div_zero();
      do_op(2'b11, 32'h1234, 32'd0, 0, "udiv_zero"); step();
      // Accepting the next op must clear DivByZero (checked inside do_op).
      do_op(2'b11, 32'd100, 32'd7, 0, "after_div_zero"); step();
   endtask

   task automatic test_back_to_back();
      do_op(2'b01, 32'hDEAD_BEEF, 32'h0000_1001, 5, "umull_stray_start");
      step();
      do_op(2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, "b2b_smull");
      // Start in the Done cycle is ignored.
      Op = 2'b01; SrcA = 32'd5; SrcB = 32'd5; Start = 1'b1;
      step();
      Start = 1'b0;
      tests_run++;
      if (Busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL start_on_done: got busy=%b expected 0", Busy);
      end
      step();
   endtask

   task automatic test_reset_mid();
      bit saw_done = 1'b0;
      Op = 2'b01; SrcA = 32'hFFFF_FFFF; SrcB = 32'hFFFF_FFFF; Start = 1'b1;
      step();
      Start = 1'b0;
      repeat (9) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_idle_zero("reset_mid_op");
      for (int i = 0; i < 40; i++) begin
         if (Done === 1'b1) saw_done = 1'b1;
         step();
      end
      tests_run++;
      if (saw_done) begin
         tests_failed++;
         $display("[TB] FAIL reset_no_done: got a Done after abandoned op, expected none");
      end
   endtask

   task automatic test_random();
      logic [1:0]  op;
      logic [31:0] a, b;
      for (int i = 0; i < 24; i++) begin
         op = 2'($urandom);
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = 32'd0;
            1: b = $urandom_range(1, 255);
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
         do_op(op, a, b, 0, "random");
         repeat ($urandom_range(1, 3)) step();
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_div_zero();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
